// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg
// Shared constants for the seq_gen sequence generator:
//   - step mode encodings (hold, LFSR, ring, Johnson)
//   - rotate direction encodings
//   - maximal-length LFSR feedback masks for widths 3..8, expressed in the
//     generator's convention (bit i set means state bit i feeds the XOR,
//     and the feedback enters at bit 0 while the state shifts left)
package seq_gen_pkg;

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_LFSR    = 2'b01;
  localparam logic [1:0] MODE_RING    = 2'b10;
  localparam logic [1:0] MODE_JOHNSON = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Maximal polynomials for common widths; widths outside 3..8 return zero
  // so a caller can tell that no default exists.
  function automatic logic [7:0] default_taps(input int unsigned width);
    logic [7:0] taps;
    case (width)
      32'd3:   taps = 8'b0000_0110;  // x^3+x^2+1
      32'd4:   taps = 8'b0000_1100;  // x^4+x^3+1
      32'd5:   taps = 8'b0001_0100;  // x^5+x^3+1
      32'd6:   taps = 8'b0011_0000;  // x^6+x^5+1
      32'd7:   taps = 8'b0110_0000;  // x^7+x^6+1
      32'd8:   taps = 8'b1011_1000;  // x^8+x^6+x^5+x^4+1
      default: taps = 8'b0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/seq_gen_next.sv
// seq_gen_next
// Purely combinational next-state function of the sequence generator.
// Ports:
//   ro        in  WIDTH  current state
//   mode      in  2      00 hold, 01 LFSR, 10 ring, 11 Johnson
//   dir       in  1      0 left, 1 right (ring/Johnson only)
//   next      out WIDTH  state after one step
//   is_lockup out 1      LFSR step from the all-zero state (next is RESET_STATE)
module seq_gen_next
  import seq_gen_pkg::*;
#(
  parameter int               WIDTH       = 5,
  parameter logic [WIDTH-1:0] TAPS        = 5'b10100,
  parameter logic [WIDTH-1:0] RESET_STATE = 5'b00001
) (
  input  logic [WIDTH-1:0] ro,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] next,
  output logic             is_lockup
);

  // Select the stepped state for the current mode and direction
  always_comb begin
    next      = ro;
    is_lockup = 1'b0;
    case (mode)
      MODE_HOLD: begin
        next = ro;
      end
      MODE_LFSR: begin
        // All-zero is a fixed point of an XOR LFSR; escape it by reseeding.
        if (ro == {WIDTH{1'b0}}) begin
          next      = RESET_STATE;
          is_lockup = 1'b1;
        end else begin
          next = {ro[WIDTH-2:0], ^(ro & TAPS)};
        end
      end
      MODE_RING: begin
        if (dir == DIR_RIGHT) begin
          next = {ro[0], ro[WIDTH-1:1]};
        end else begin
          next = {ro[WIDTH-2:0], ro[WIDTH-1]};
        end
      end
      MODE_JOHNSON: begin
        if (dir == DIR_RIGHT) begin
          next = {~ro[0], ro[WIDTH-1:1]};
        end else begin
          next = {ro[WIDTH-2:0], ~ro[WIDTH-1]};
        end
      end
      default: begin
        next = ro;
      end
    endcase
  end

endmodule

// File: rtl/seq_gen.sv
// seq_gen
// Loadable WIDTH-bit sequence generator with hold / LFSR / ring / Johnson
// stepping, seed-return detection, period measurement and LFSR lockup
// recovery. All outputs come straight from registers.
// Ports:
//   CLK      in  1        clock, rising edge
//   Reset_n  in  1        asynchronous active-low reset
//   Load     in  1        load inState as state and seed (beats Enable)
//   Enable   in  1        take one step this cycle
//   Mode     in  2        00 hold, 01 LFSR, 10 ring, 11 Johnson
//   Dir      in  1        0 left, 1 right (ring/Johnson only)
//   inState  in  WIDTH    load value
//   RO       out WIDTH    current state
//   Wrap     out 1        pulse: state just returned to the seed
//   Lockup   out 1        pulse: LFSR zero-state recovery happened
//   Period   out WIDTH+1  step count of the last completed cycle
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int               WIDTH       = 5,
  parameter logic [WIDTH-1:0] TAPS        = 5'b10100,
  parameter logic [WIDTH-1:0] RESET_STATE = 5'b00001
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic             Enable,
  input  logic [1:0]       Mode,
  input  logic             Dir,
  input  logic [WIDTH-1:0] inState,
  output logic [WIDTH-1:0] RO,
  output logic             Wrap,
  output logic             Lockup,
  output logic [WIDTH:0]   Period
);

  localparam logic [WIDTH:0] CNT_MAX  = {(WIDTH+1){1'b1}};
  localparam logic [WIDTH:0] CNT_ZERO = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] ro_r;
  logic [WIDTH-1:0] seed_r;
  logic [WIDTH:0]   count_r;
  logic [WIDTH:0]   period_r;
  logic             wrap_r;
  logic             lockup_r;

  logic [WIDTH-1:0] next_s;
  logic             lockup_s;
  logic [WIDTH:0]   count_inc_s;
  logic             step_s;
  logic             seed_hit_s;

  seq_gen_next #(
    .WIDTH       (WIDTH),
    .TAPS        (TAPS),
    .RESET_STATE (RESET_STATE)
  ) u_next (
    .ro        (ro_r),
    .mode      (Mode),
    .dir       (Dir),
    .next      (next_s),
    .is_lockup (lockup_s)
  );

  // Step qualification, saturating count increment and seed-return detection
  always_comb begin
    step_s      = Enable && (Mode != MODE_HOLD);
    count_inc_s = (count_r == CNT_MAX) ? CNT_MAX : (count_r + CNT_ONE);
    // Once the counter has saturated the true period is unknown, so a
    // return to the seed is no longer reported.
    seed_hit_s  = (next_s == seed_r) && (count_r != CNT_MAX);
  end

  // State, seed, counter and pulse registers (Load beats Enable)
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ro_r     <= RESET_STATE;
      seed_r   <= RESET_STATE;
      count_r  <= CNT_ZERO;
      period_r <= CNT_ZERO;
      wrap_r   <= 1'b0;
      lockup_r <= 1'b0;
    end else if (Load) begin
      ro_r     <= inState;
      seed_r   <= inState;
      count_r  <= CNT_ZERO;
      wrap_r   <= 1'b0;
      lockup_r <= 1'b0;
    end else if (step_s) begin
      ro_r <= next_s;
      if (lockup_s) begin
        count_r  <= CNT_ZERO;
        wrap_r   <= 1'b0;
        lockup_r <= 1'b1;
      end else if (seed_hit_s) begin
        period_r <= count_r + CNT_ONE;
        count_r  <= CNT_ZERO;
        wrap_r   <= 1'b1;
        lockup_r <= 1'b0;
      end else begin
        count_r  <= count_inc_s;
        wrap_r   <= 1'b0;
        lockup_r <= 1'b0;
      end
    end else begin
      wrap_r   <= 1'b0;
      lockup_r <= 1'b0;
    end
  end

  assign RO     = ro_r;
  assign Wrap   = wrap_r;
  assign Lockup = lockup_r;
  assign Period = period_r;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen
// Directed self-checking bench for seq_gen (WIDTH=5, default taps).
module tb_seq_gen;
  import seq_gen_pkg::*;

  logic       CLK;
  logic       Reset_n;
  logic       Load;
  logic       Enable;
  logic [1:0] Mode;
  logic       Dir;
  logic [4:0] inState;
  logic [4:0] RO;
  logic       Wrap;
  logic       Lockup;
  logic [5:0] Period;

  int n_assert = 0;
  int n_fail   = 0;

  seq_gen dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .Load    (Load),
    .Enable  (Enable),
    .Mode    (Mode),
    .Dir     (Dir),
    .inState (inState),
    .RO      (RO),
    .Wrap    (Wrap),
    .Lockup  (Lockup),
    .Period  (Period)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already driven, outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [4:0] v);
    Load    = 1'b1;
    inState = v;
    tick();
    Load    = 1'b0;
  endtask

  logic [4:0] ring_l [5] = '{5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
  logic [4:0] ring_r [5] = '{5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b00010};
  logic [4:0] john_l [10] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                              5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
  logic [4:0] lfsr_first [3] = '{5'b00100, 5'b01001, 5'b10010};
  int extra_wraps;

  initial begin
    Reset_n = 1'b0;
    Load    = 1'b0;
    Enable  = 1'b0;
    Mode    = MODE_HOLD;
    Dir     = DIR_LEFT;
    inState = 5'b00000;

    // Reset state
    #12;
    chk("reset_ro", 32'(RO), 32'(5'b00001));
    chk("reset_period", 32'(Period), 32'(6'd0));
    chk("reset_wrap", 32'(Wrap), 32'(1'b0));
    chk("reset_lockup", 32'(Lockup), 32'(1'b0));
    #10;
    Reset_n = 1'b1;
    tick();
    tick();
    chk("idle_ro", 32'(RO), 32'(5'b00001));
    chk("idle_wrap", 32'(Wrap), 32'(1'b0));

    // LFSR full period from 00010
    do_load(5'b00010);
    chk("load_ro", 32'(RO), 32'(5'b00010));
    Mode   = MODE_LFSR;
    Enable = 1'b1;
    extra_wraps = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (i < 3) chk("lfsr_seq", 32'(RO), 32'(lfsr_first[i]));
      if (i < 30 && Wrap) extra_wraps++;
    end
    chk("lfsr_no_early_wrap", 32'(extra_wraps), 32'd0);
    chk("lfsr_wrap_ro", 32'(RO), 32'(5'b00010));
    chk("lfsr_wrap", 32'(Wrap), 32'(1'b1));
    chk("lfsr_period", 32'(Period), 32'(6'd31));
    Enable = 1'b0;
    tick();
    chk("wrap_one_cycle", 32'(Wrap), 32'(1'b0));

    // Ring left then right
    do_load(5'b00010);
    Mode   = MODE_RING;
    Dir    = DIR_LEFT;
    Enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ring_l_ro", 32'(RO), 32'(ring_l[i]));
      chk("ring_l_wrap", 32'(Wrap), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("ring_l_period", 32'(Period), 32'(6'd5));
    Enable = 1'b0;
    do_load(5'b00010);
    Dir    = DIR_RIGHT;
    Enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ring_r_ro", 32'(RO), 32'(ring_r[i]));
      chk("ring_r_wrap", 32'(Wrap), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("ring_r_period", 32'(Period), 32'(6'd5));
    Enable = 1'b0;

    // Johnson left from 00000
    do_load(5'b00000);
    Mode   = MODE_JOHNSON;
    Dir    = DIR_LEFT;
    Enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("john_ro", 32'(RO), 32'(john_l[i]));
      chk("john_wrap", 32'(Wrap), (i == 9) ? 32'd1 : 32'd0);
    end
    chk("john_period", 32'(Period), 32'(6'd10));
    Enable = 1'b0;

    // Lockup recovery; count restarts at 0 so the Johnson return to seed 00000
    // from 00001 takes 9 steps.
    do_load(5'b00000);
    Mode   = MODE_LFSR;
    Enable = 1'b1;
    tick();
    chk("lock_ro", 32'(RO), 32'(5'b00001));
    chk("lock_pulse", 32'(Lockup), 32'(1'b1));
    chk("lock_wrap", 32'(Wrap), 32'(1'b0));
    chk("lock_period_kept", 32'(Period), 32'(6'd10));
    Enable = 1'b0;
    tick();
    chk("lock_one_cycle", 32'(Lockup), 32'(1'b0));
    Mode   = MODE_JOHNSON;
    Enable = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk("lock_count_ro", 32'(RO), 32'(5'b00000));
    chk("lock_count_wrap", 32'(Wrap), 32'(1'b1));
    chk("lock_count_period", 32'(Period), 32'(6'd9));
    Enable = 1'b0;

    // Hold steps freeze state and count
    do_load(5'b00010);
    Mode   = MODE_RING;
    Dir    = DIR_LEFT;
    Enable = 1'b1;
    tick();
    tick();
    Mode = MODE_HOLD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ro", 32'(RO), 32'(5'b01000));
      chk("hold_wrap", 32'(Wrap), 32'(1'b0));
    end
    Mode = MODE_RING;
    tick();
    tick();
    tick();
    chk("hold_resume_ro", 32'(RO), 32'(5'b00010));
    chk("hold_resume_wrap", 32'(Wrap), 32'(1'b1));
    chk("hold_resume_period", 32'(Period), 32'(6'd5));
    Enable = 1'b0;

    // Ring fixed point wraps every step
    do_load(5'b11111);
    Enable = 1'b1;
    tick();
    chk("fixed_wrap1", 32'(Wrap), 32'(1'b1));
    chk("fixed_period", 32'(Period), 32'(6'd1));
    tick();
    chk("fixed_wrap2", 32'(Wrap), 32'(1'b1));
    chk("fixed_ro", 32'(RO), 32'(5'b11111));
    Enable = 1'b0;

    // Saturated count suppresses the wrap: seed 00000, lockup to 00001,
    // 93 LFSR steps (count pins at 63), then 9 Johnson steps back to 00000.
    do_load(5'b00000);
    Mode   = MODE_LFSR;
    Enable = 1'b1;
    tick();
    extra_wraps = 0;
    for (int i = 0; i < 93; i++) begin
      tick();
      if (Wrap) extra_wraps++;
    end
    chk("sat_lfsr_ro", 32'(RO), 32'(5'b00001));
    Mode = MODE_JOHNSON;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (Wrap) extra_wraps++;
    end
    chk("sat_ro", 32'(RO), 32'(5'b00000));
    chk("sat_no_wrap", 32'(extra_wraps), 32'd0);
    chk("sat_period_kept", 32'(Period), 32'(6'd1));
    Enable = 1'b0;

    // Load beats Enable
    Mode    = MODE_LFSR;
    Enable  = 1'b1;
    Load    = 1'b1;
    inState = 5'b10101;
    tick();
    Load = 1'b0;
    chk("load_prio_ro", 32'(RO), 32'(5'b10101));
    chk("load_prio_wrap", 32'(Wrap), 32'(1'b0));
    Mode = MODE_HOLD;
    tick();
    tick();
    chk("hold_freeze_ro", 32'(RO), 32'(5'b10101));

    // Asynchronous reset mid-run
    Mode = MODE_RING;
    Dir  = DIR_LEFT;
    tick();
    chk("pre_reset_ro", 32'(RO), 32'(5'b01011));
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_ro", 32'(RO), 32'(5'b00001));
    chk("async_reset_period", 32'(Period), 32'(6'd0));
    #1;
    Reset_n = 1'b1;
    tick();
    chk("post_reset_step", 32'(RO), 32'(5'b00010));
    Enable = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Parametrised sequence generator for state-sequencing and pseudo-random stimulus in the practice designs. It holds a WIDTH-bit state register that can be loaded and then stepped under one of four modes: hold, Fibonacci LFSR, ring rotate, or Johnson count. Ring and Johnson modes rotate in either direction. It also measures the sequence period, flags every return to the loaded seed, and recovers automatically from LFSR all-zero lockup.

## Interface
Parameters:
- WIDTH, 5, state width (≥2)
- TAPS, 5'b10100, LFSR feedback mask; bit i set means RO[i] feeds the XOR (default is x^5+x^3+1, maximal length 31)
- RESET_STATE, 5'b00001, state loaded on reset and on lockup recovery

Ports:
- CLK  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Load  in  1  load inState as new state and seed
- Enable  in  1  advance one step this cycle
- Mode  in  2  00 hold, 01 LFSR, 10 ring, 11 Johnson
- Dir  in  1  0 left, 1 right (ring/Johnson only)
- inState  in  WIDTH  load value
- RO  out  WIDTH  current state
- Wrap  out  1  one-cycle pulse: state just returned to seed
- Lockup  out  1  one-cycle pulse: LFSR zero-state recovery occurred
- Period  out  WIDTH+1  step count of the last completed cycle

## Operation
- Registers: RO, Seed, Count (WIDTH+1 bits), Period, Wrap, Lockup.
- Reset (Reset_n=0, asynchronous): RO=Seed=RESET_STATE, Count=0, Period=0, Wrap=0, Lockup=0.
- Priority on each edge: Load > Enable > idle.
- Load: RO←inState, Seed←inState, Count←0, Wrap←0, Lockup←0. Period is unchanged. Mode and Enable are ignored that cycle.
- Step (Enable=1, Load=0). Next state per Mode:
  - 00: RO unchanged, Count unchanged, no flags.
  - 01: RO←{RO[W-2:0], ^(RO & TAPS)}. Dir is ignored.
  - 10, Dir=0: {RO[W-2:0], RO[W-1]}. Dir=1: {RO[0], RO[W-1:1]}.
  - 11, Dir=0: {RO[W-2:0], ~RO[W-1]}. Dir=1: {~RO[0], RO[W-1:1]}.
- Lockup: a step in mode 01 with RO==0 sets RO←RESET_STATE, Count←0 and pulses Lockup. The wrap check is skipped for that step.
- Wrap check, for every non-hold step except lockup:
  - If next state == Seed: Wrap←1, Period←Count+1, Count←0.
  - Otherwise: Count←Count+1, saturating at all-ones. Wrap←0.
- A saturated Count never produces a wrap until the next Load or reset.
- Idle cycles (Enable=0) and hold steps clear the Wrap and Lockup pulses and leave Count unchanged.
- Mode and Dir changes mid-sequence take effect on the next step. Count and Seed are not cleared.
- Fixed points (ring 00000/11111) wrap on every step, giving Period=1.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Load or step at edge N is visible on RO after edge N. Wrap, Lockup and Period update on the same edge.
- Throughput: one step per clock.
- Reset asserted mid-sequence forces reset values immediately, without waiting for a clock edge. The first step is taken at the first enabled edge after Reset_n rises.

## Structure
- Package seq_gen_pkg holds:
  - mode encoding constants MODE_HOLD, MODE_LFSR, MODE_RING, MODE_JOHNSON;
  - DIR_LEFT/DIR_RIGHT;
  - default TAPS for widths 3–8 (maximal polynomials).
- Sub-module seq_gen_next: purely combinational next-state function (RO, Mode, Dir → next, is_lockup).
- Top level: registers plus wrap and period logic.

## Test plan
- Reset at t=0, release, Enable=0: RO=00001, Period=0, Wrap=0. Reasserting Reset_n low mid-run returns RO=00001 without a clock edge.
- Load 00010, Mode=01, Enable for 31 cycles:
  - RO sequence 00100, 01001, 10010, …
  - Wrap pulses exactly on step 31, with RO=00010 and Period=31.
  - No other Wrap pulse occurs.
- Load 00010, Mode=10, Dir=0: RO 00100, 01000, 10000, 00001, 00010; Wrap on step 5, Period=5. Repeat with Dir=1: 00001, 10000, …, Period=5.
- Load 00000, Mode=11, Dir=0: RO 00001, 00011, …, 11111, 11110, …, 00000; Wrap at step 10, Period=10.
- Load 00000, Mode=01, one step: RO=00001, Lockup=1 for one cycle, Wrap=0, Count=0.
- Load=1 and Enable=1 in the same cycle with inState=10101: RO=10101, no step taken. Mode=00 with Enable=1: RO and Count frozen.
